// File: rtl/fifo_wr_arb_ctrl_pkg.sv
// Shared helpers and constants for the FIFO write-side controller.
package fifo_wr_arb_ctrl_pkg;

    // Pointer helpers work on a 32-bit container; callers zero-extend and truncate.
    localparam int unsigned PTR_CONTAINER_W = 32;

    // Controller states (legacy-compatible constants).
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    function automatic logic [PTR_CONTAINER_W-1:0] bin2gray(input logic [PTR_CONTAINER_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Binary bit i is the XOR of all Gray bits at and above i.
    function automatic logic [PTR_CONTAINER_W-1:0] gray2bin(input logic [PTR_CONTAINER_W-1:0] g);
        logic [PTR_CONTAINER_W-1:0] b;
        b = g;
        for (int i = 1; i < PTR_CONTAINER_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_arb_ctrl_if.sv
// Requester / FIFO-memory / synchronizer signals of the write-side controller.
interface fifo_wr_arb_ctrl_if #(
    parameter int unsigned addrbits = 8,
    parameter int unsigned DWIDTH   = 8,
    parameter int unsigned NREQ     = 2
);
    logic                     flush;
    logic [NREQ-1:0]          req;
    logic [NREQ*DWIDTH-1:0]   req_data;
    logic [NREQ-1:0]          gnt;
    logic [addrbits:0]        sync_rdptr;
    logic                     wr_en;
    logic [addrbits-1:0]      wr_addr;
    logic [DWIDTH-1:0]        wr_data;
    logic [addrbits:0]        wrptr;
    logic                     full;
    logic                     almost_full;
    logic                     flush_busy;

    // Environment side: requesters, flush source and read-pointer synchronizer.
    modport master (
        output flush, req, req_data, sync_rdptr,
        input  gnt, wr_en, wr_addr, wr_data, wrptr, full, almost_full, flush_busy
    );

    // Controller side.
    modport slave (
        input  flush, req, req_data, sync_rdptr,
        output gnt, wr_en, wr_addr, wr_data, wrptr, full, almost_full, flush_busy
    );
endinterface

// File: rtl/fifo_wr_arb_ctrl_rr_arbiter.sv
// Round-robin arbiter: priority starts one past the last granted requester.
module fifo_wr_arb_ctrl_rr_arbiter #(
    parameter int unsigned NREQ = 2,
    localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk_in,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    input  logic            enable_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   gnt_idx_o   // index granted now; becomes the last-grant pointer
);
    logic [IW-1:0] last_q, last_d;

    // Scan requesters starting after the last winner; first active one wins.
    always_comb begin
        logic          found;
        logic [IW-1:0] idx;
        gnt_o     = '0;
        gnt_idx_o = '0;
        last_d    = last_q;
        found     = 1'b0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = IW'((int'(last_q) + 1 + k) % int'(NREQ));
            if (enable_i && !found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
                last_d     = idx;
                found      = 1'b1;
            end
        end
    end

    // Last-grant pointer; reset value puts requester 0 first.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            last_q <= IW'(NREQ - 1);
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/fifo_wr_arb_ctrl.sv
// Write-side controller of the async FIFO: arbitration, write pointer, full flags, flush.
module fifo_wr_arb_ctrl
    import fifo_wr_arb_ctrl_pkg::*;
#(
    parameter int unsigned addrbits  = 8,
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned NREQ      = 2,
    parameter int unsigned AF_MARGIN = 4,
    parameter int unsigned FLUSH_CYC = 4
) (
    input logic               clk_in,
    input logic               rst,
    fifo_wr_arb_ctrl_if.slave bus
);
    localparam int unsigned PW    = addrbits + 1;
    localparam int unsigned DEPTH = 2 ** addrbits;
    localparam int unsigned CW    = $clog2(FLUSH_CYC) + 1;
    localparam int unsigned IW    = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [0:0]          state_q, state_d;
    logic [PW-1:0]       bin_q, bin_d;
    logic                wr_en_q, wr_en_d;
    logic [addrbits-1:0] wr_addr_q, wr_addr_d;
    logic [DWIDTH-1:0]   wr_data_q, wr_data_d;
    logic [PW-1:0]       wrptr_q, wrptr_d;
    logic                full_q, full_d;
    logic                af_q, af_d;
    logic [CW-1:0]       fcnt_q, fcnt_d;

    logic                arb_en;
    logic [NREQ-1:0]     gnt;
    logic [IW-1:0]       gnt_idx;
    logic [PW-1:0]       rd_bin;
    logic [PW-1:0]       used;
    logic [PW:0]         free;

    // Grant only while running, not flushing now, not full, and outside reset.
    assign arb_en = !rst && (state_q == ST_RUN) && !bus.flush && !full_q;
    assign rd_bin = PW'(gray2bin(PTR_CONTAINER_W'(bus.sync_rdptr)));

    fifo_wr_arb_ctrl_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk_in    (clk_in),
        .rst       (rst),
        .req_i     (bus.req),
        .enable_i  (arb_en),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    // Next-state: flush sequencing, write strobe/pointer update, full flag evaluation.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wrptr_d   = wrptr_q;
        full_d    = full_q;
        af_d      = af_q;
        fcnt_d    = fcnt_q;
        used      = '0;
        free      = '0;
        case (state_q)
            ST_RUN: begin
                if (bus.flush) begin
                    state_d   = ST_FLUSH;
                    bin_d     = '0;
                    wr_addr_d = '0;
                    wr_data_d = '0;
                    wrptr_d   = '0;
                    full_d    = 1'b0;
                    af_d      = 1'b0;
                    fcnt_d    = '0;
                end else begin
                    if (|gnt) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = bin_q[addrbits-1:0];
                        wr_data_d = bus.req_data[gnt_idx*DWIDTH +: DWIDTH];
                        bin_d     = bin_q + 1'b1;
                    end
                    wrptr_d = PW'(bin2gray(PTR_CONTAINER_W'(bin_d)));
                    // Full when write is exactly one lap ahead: top two Gray bits inverted.
                    full_d  = (wrptr_d == {~bus.sync_rdptr[PW-1 -: 2], bus.sync_rdptr[PW-3:0]});
                    used    = bin_d - rd_bin;
                    free    = (PW+1)'(DEPTH) - {1'b0, used};
                    af_d    = (free <= (PW+1)'(AF_MARGIN));
                end
            end
            default: begin
                // Hold long enough for the read side to see the zeroed pointer.
                if (!bus.flush && fcnt_q >= CW'(FLUSH_CYC - 1)) begin
                    state_d = ST_RUN;
                end else if (fcnt_q < CW'(FLUSH_CYC - 1)) begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
        endcase
    end

    // State and registered outputs; async reset drops any in-flight write.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            bin_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wrptr_q   <= '0;
            full_q    <= 1'b0;
            af_q      <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wrptr_q   <= wrptr_d;
            full_q    <= full_d;
            af_q      <= af_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign bus.gnt         = gnt;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.wrptr       = wrptr_q;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.flush_busy  = (state_q == ST_FLUSH);
endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Bench for fifo_wr_arb_ctrl: table vectors, directed corner sequences, random vs. model.
module tb_fifo_wr_arb_ctrl;
    localparam int unsigned AB    = 3;
    localparam int unsigned DW    = 8;
    localparam int unsigned NR    = 2;
    localparam int unsigned AFM   = 2;
    localparam int unsigned FCYC  = 4;
    localparam int          DEPTH = 8;
    localparam int          PMOD  = 16;

    logic clk_in;
    logic rst;

    fifo_wr_arb_ctrl_if #(.addrbits(AB), .DWIDTH(DW), .NREQ(NR)) bus ();

    fifo_wr_arb_ctrl #(
        .addrbits  (AB),
        .DWIDTH    (DW),
        .NREQ      (NR),
        .AF_MARGIN (AFM),
        .FLUSH_CYC (FCYC)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Reference model state: word count, last winner, flush phase, expected registers.
    int   m_wr, m_last, m_fcnt;
    bit   m_busy;
    logic e_wr_en, e_full, e_af;
    int   e_addr, e_data, e_wrptr;
    logic [1:0] g_obs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all();
        chk("wr_en", bus.wr_en, e_wr_en);
        chk("wr_addr", bus.wr_addr, e_addr);
        chk("wr_data", bus.wr_data, e_data);
        chk("wrptr", bus.wrptr, e_wrptr);
        chk("full", bus.full, e_full);
        chk("almost_full", bus.almost_full, e_af);
        chk("flush_busy", bus.flush_busy, m_busy);
    endtask

    task automatic model_reset();
        m_wr = 0; m_last = NR - 1; m_fcnt = 0; m_busy = 0;
        e_wr_en = 0; e_full = 0; e_af = 0; e_addr = 0; e_data = 0; e_wrptr = 0;
    endtask

    // Assert reset at posedge+1, check outputs at once, release one edge later.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_gnt", bus.gnt, 0);
        chk_all();
        @(posedge clk_in);
        #1;
        rst = 1'b0;
    endtask

    // One clock of stimulus; entered and left at posedge+1.
    task automatic step(input logic f, input logic [1:0] r, input logic [7:0] d0,
                        input logic [7:0] d1, input int rd);
        logic [1:0] eg;
        int gi, idx, used;
        bus.flush      = f;
        bus.req        = r;
        bus.req_data   = {d1, d0};
        bus.sync_rdptr = 4'(rd ^ (rd >> 1));
        eg = 2'b00;
        gi = 0;
        if (!m_busy && !f && !e_full) begin
            for (int k = 0; k < NR; k++) begin
                idx = (m_last + 1 + k) % NR;
                if (r[idx] && eg == 2'b00) begin
                    eg[idx] = 1'b1;
                    gi = idx;
                end
            end
        end
        @(negedge clk_in);
        chk("gnt", bus.gnt, eg);
        g_obs = bus.gnt;
        @(posedge clk_in);
        if (m_busy) begin
            if (!f && m_fcnt >= FCYC - 1) m_busy = 0;
            else m_fcnt++;
        end else if (f) begin
            m_busy = 1; m_fcnt = 0; m_wr = 0;
            e_wr_en = 0; e_addr = 0; e_data = 0; e_wrptr = 0; e_full = 0; e_af = 0;
        end else begin
            e_wr_en = (eg != 2'b00);
            if (eg != 2'b00) begin
                e_addr = m_wr % DEPTH;
                e_data = (gi == 1) ? int'(d1) : int'(d0);
                m_wr   = (m_wr + 1) % PMOD;
                m_last = gi;
            end
            used    = (m_wr - rd + PMOD) % PMOD;
            e_wrptr = m_wr ^ (m_wr >> 1);
            e_full  = (used == DEPTH);
            e_af    = ((DEPTH - used) <= AFM);
        end
        #1;
        chk_all();
    endtask

    typedef struct {
        logic [1:0] req;
        logic [1:0] exp_gnt;
        int         exp_addr;
        int         exp_wrptr;
    } vec_t;

    vec_t rr_tab[4];
    int   rd, cnt, bc, n;
    bit   f;

    initial begin
        rr_tab[0] = '{2'b11, 2'b01, 0, 1};
        rr_tab[1] = '{2'b11, 2'b10, 1, 3};
        rr_tab[2] = '{2'b11, 2'b01, 2, 2};
        rr_tab[3] = '{2'b11, 2'b10, 3, 6};

        bus.flush = 0; bus.req = 0; bus.req_data = 0; bus.sync_rdptr = 0;
        rst = 1'b1;
        model_reset();
        @(posedge clk_in);
        #1;
        do_reset();

        // Round robin with both requesters held.
        for (int i = 0; i < 4; i++) begin
            step(0, rr_tab[i].req, 8'(8'hA0 + i), 8'(8'hB0 + i), 0);
            chk("rr_gnt", g_obs, rr_tab[i].exp_gnt);
            chk("rr_addr", bus.wr_addr, rr_tab[i].exp_addr);
            chk("rr_wrptr", bus.wrptr, rr_tab[i].exp_wrptr);
        end

        // Full: eight writes, then blocked until the read pointer moves.
        do_reset();
        for (int i = 0; i < 8; i++) step(0, 2'b01, 8'(i), 8'h00, 0);
        chk("full_after8", bus.full, 1);
        step(0, 2'b11, 8'h11, 8'h22, 0);
        chk("full_nogrant", g_obs, 0);
        step(0, 2'b11, 8'h11, 8'h22, 1);
        chk("full_release", bus.full, 0);
        step(0, 2'b11, 8'h33, 8'h44, 1);
        chk("full_resume", (g_obs != 2'b00), 1);

        // Almost full at free slots <= 2.
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 2'b01, 8'(i), 8'h00, 0);
        chk("af_used5", bus.almost_full, 0);
        step(0, 2'b01, 8'h55, 8'h00, 0);
        chk("af_used6", bus.almost_full, 1);
        step(0, 2'b00, 8'h00, 8'h00, 1);
        chk("af_back5", bus.almost_full, 0);

        // Pointer wrap with read side trailing by three.
        do_reset();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            rd = (cnt >= 3) ? (cnt - 3) % PMOD : 0;
            step(0, 2'b01, 8'(i), 8'h00, rd);
            cnt++;
            chk("wrap_nofull", bus.full, 0);
            if (cnt == 16) begin
                chk("wrap_ptr0", bus.wrptr, 0);
                chk("wrap_addr7", bus.wr_addr, 7);
            end
            if (cnt == 17) chk("wrap_addr0", bus.wr_addr, 0);
        end

        // Flush with five words stored and both requesters pending.
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 2'b01, 8'(i), 8'h00, 0);
        step(1, 2'b11, 8'h77, 8'h88, 0);
        chk("flush_gnt", g_obs, 0);
        chk("flush_wrptr", bus.wrptr, 0);
        chk("flush_full", bus.full, 0);
        chk("flush_busy", bus.flush_busy, 1);
        step(1, 2'b11, 8'h77, 8'h88, 0);
        bc = 2;
        n = 0;
        while (bus.flush_busy && n < 20) begin
            step(0, 2'b11, 8'h77, 8'h88, 0);
            if (bus.flush_busy) bc++;
            n++;
        end
        chk("flush_timeout", bus.flush_busy, 0);
        chk("flush_len", (bc >= FCYC), 1);
        step(0, 2'b01, 8'h99, 8'h00, 0);
        chk("flush_resume_gnt", g_obs, 2'b01);
        chk("flush_resume_addr", bus.wr_addr, 0);

        // Reset while a write is in flight.
        step(0, 2'b11, 8'hC1, 8'hC2, 0);
        chk("midwr_en", bus.wr_en, 1);
        do_reset();
        step(0, 2'b01, 8'hD0, 8'h00, 0);
        chk("post_rst_gnt", g_obs, 2'b01);
        chk("post_rst_addr", bus.wr_addr, 0);

        // Random traffic against the model.
        do_reset();
        rd = 0;
        for (int i = 0; i < 1500; i++) begin
            f = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
            if (m_busy || f) rd = 0;
            else if (((m_wr - rd + PMOD) % PMOD) > 0 && $urandom_range(0, 1) == 1)
                rd = (rd + 1) % PMOD;
            step(f, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
